// File: rtl/dec_mul_round_pkg.sv
// Shared definitions for the decimal multiplier rounding stage:
// rounding-mode and FSM encodings, BCD nibble constants, round-up decision.
package dec_mul_round_pkg;

  localparam logic [3:0] BCD_NINE = 4'h9;
  localparam logic [3:0] BCD_ZERO = 4'h0;

  typedef enum logic [2:0] {
    RND_RNE = 3'd0,
    RND_RNA = 3'd1,
    RND_RTZ = 3'd2,
    RND_RUP = 3'd3,
    RND_RDN = 3'd4
  } rnd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECIDE,
    ST_INCR,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    TAIL_LT,
    TAIL_EQ,
    TAIL_GT
  } tail_e;

  // Round-up decision; unlisted mode codes fall back to round-half-even.
  function automatic logic round_up(input logic [2:0] mode, input tail_e tail,
                                    input logic tail_nz, input logic lsd_odd,
                                    input logic sign);
    case (mode)
      RND_RNA: round_up = (tail != TAIL_LT);
      RND_RTZ: round_up = 1'b0;
      RND_RUP: round_up = tail_nz & ~sign;
      RND_RDN: round_up = tail_nz & sign;
      default: round_up = (tail == TAIL_GT) | ((tail == TAIL_EQ) & lsd_odd);
    endcase
  endfunction

endpackage

// File: rtl/dec_mul_round_if.sv
// Beat-in / result-out handshake bundle of the rounding stage.
interface dec_mul_round_if #(
  parameter int unsigned NDIG  = 7,
  parameter int unsigned NGRS  = 3,
  parameter int unsigned EXP_W = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [4*NDIG-1:0]   mant_in;
  logic [4*NGRS-1:0]   grs_in;
  logic [EXP_W:0]      exp_in;
  logic                uf_in;
  logic                sign_in;
  logic [2:0]          rnd_mode;
  logic                out_valid;
  logic                out_ready;
  logic [4*NDIG-1:0]   mant_out;
  logic [EXP_W-1:0]    exp_out;
  logic                sign_out;
  logic                ovf_out;
  logic                inexact_out;
  logic                uf_out;

  modport master (
    output in_valid, mant_in, grs_in, exp_in, uf_in, sign_in, rnd_mode, out_ready,
    input  in_ready, out_valid, mant_out, exp_out, sign_out, ovf_out, inexact_out, uf_out
  );

  modport slave (
    input  in_valid, mant_in, grs_in, exp_in, uf_in, sign_in, rnd_mode, out_ready,
    output in_ready, out_valid, mant_out, exp_out, sign_out, ovf_out, inexact_out, uf_out
  );
endinterface

// File: rtl/dec_mul_round_bcd_digit_inc.sv
// Single BCD digit incrementer: 9 + carry wraps to 0 and carries on.
module bcd_digit_inc
  import dec_mul_round_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       carry_in,
  output logic [3:0] digit_out,
  output logic       carry_out
);
  // Add the incoming carry to one digit with decimal wrap.
  always_comb begin
    digit_out = digit;
    carry_out = 1'b0;
    if (carry_in) begin
      if (digit == BCD_NINE) begin
        digit_out = BCD_ZERO;
        carry_out = 1'b1;
      end else begin
        digit_out = digit + 4'd1;
      end
    end
  end
endmodule

// File: rtl/dec_mul_round.sv
// Decimal rounding stage: decides round-up from the G/R/S tail, then ripples
// the increment one BCD digit per cycle and renormalizes on all-nines carry-out.
module dec_mul_round
  import dec_mul_round_pkg::*;
#(
  parameter int unsigned NDIG  = 7,
  parameter int unsigned NGRS  = 3,
  parameter int unsigned EXP_W = 8
) (
  input logic             clk,
  input logic             rst_n,
  dec_mul_round_if.slave  bus
);
  localparam int unsigned IDX_W = $clog2(NDIG);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);
  localparam logic [NDIG-1:0][3:0] MANT_RENORM = {4'd1, {(NDIG-1){BCD_ZERO}}};
  localparam logic [NDIG-1:0][3:0] MANT_SAT    = {NDIG{BCD_NINE}};

  state_e                state, state_nxt;
  logic [NDIG-1:0][3:0]  mant_r;
  logic [4*NGRS-1:0]     grs_r;
  logic [EXP_W:0]        exp_r;
  logic                  sign_r;
  logic                  uf_r;
  logic [2:0]            mode_r;
  logic [IDX_W-1:0]      idx;

  logic [3:0]            g_dig;
  logic                  rs_nz;
  tail_e                 tail;
  logic                  up;
  logic [3:0]            dig_nxt;
  logic                  carry;
  logic                  ovf;

  assign g_dig = grs_r[4*NGRS-1 -: 4];
  assign rs_nz = |grs_r[4*NGRS-5:0];

  // Tail relation against one half ulp, and the round-up decision.
  always_comb begin
    tail = TAIL_LT;
    if (g_dig > 4'd5 || (g_dig == 4'd5 && rs_nz)) tail = TAIL_GT;
    else if (g_dig == 4'd5)                          tail = TAIL_EQ;
    up = round_up(mode_r, tail, |grs_r, mant_r[0][0], sign_r);
  end

  // Only reached while a carry is still propagating, so carry_in is always set.
  bcd_digit_inc u_inc (
    .digit     (mant_r[idx]),
    .carry_in  (1'b1),
    .digit_out (dig_nxt),
    .carry_out (carry)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.in_valid) state_nxt = ST_DECIDE;
      ST_DECIDE: state_nxt = up ? ST_INCR : ST_DONE;
      ST_INCR:   if (!carry || idx == LAST_IDX) state_nxt = ST_DONE;
      ST_DONE:   if (bus.out_ready) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Beat capture and digit-serial increment datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mant_r <= '0;
      grs_r  <= '0;
      exp_r  <= '0;
      sign_r <= 1'b0;
      uf_r   <= 1'b0;
      mode_r <= '0;
      idx    <= '0;
    end else begin
      case (state)
        ST_IDLE: if (bus.in_valid) begin
          mant_r <= bus.mant_in;
          grs_r  <= bus.grs_in;
          exp_r  <= bus.exp_in;
          sign_r <= bus.sign_in;
          uf_r   <= bus.uf_in;
          mode_r <= bus.rnd_mode;
          idx    <= '0;
        end
        ST_INCR: begin
          if (carry && idx == LAST_IDX) begin
            mant_r <= MANT_RENORM;
            exp_r  <= exp_r + 1'b1;
          end else begin
            mant_r[idx] <= dig_nxt;
          end
          idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs come straight off the working registers, saturated on overflow.
  assign ovf             = exp_r[EXP_W];
  assign bus.in_ready    = (state == ST_IDLE);
  assign bus.out_valid   = (state == ST_DONE);
  assign bus.mant_out    = ovf ? MANT_SAT : mant_r;
  assign bus.exp_out     = ovf ? '1 : exp_r[EXP_W-1:0];
  assign bus.sign_out    = sign_r;
  assign bus.ovf_out     = ovf;
  assign bus.inexact_out = (|grs_r) | ovf;
  assign bus.uf_out      = uf_r;

endmodule
